// File: rtl/seq_param_multiplier.sv
// Sequential shift-add multiplier with valid/ready handshakes.
// Handles one bit of |b| per clock and applies the sign to the final product.
module seq_param_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             neg_q, neg_d;

    logic             a_neg, b_neg;
    logic [PW-1:0]    part, acc_sum;

    always_comb begin
        a_neg   = signed_mode & a[WIDTH-1];
        b_neg   = signed_mode & b[WIDTH-1];
        part    = PW'(mag_a_q) << cnt_q;
        acc_sum = mag_b_q[cnt_q] ? (acc_q + part) : acc_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits
                    mag_a_d = a_neg ? (~a + WIDTH'(1)) : a;
                    mag_b_d = b_neg ? (~b + WIDTH'(1)) : b;
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    prod_d  = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign product   = prod_q;

endmodule

// File: tb/tb_seq_param_multiplier.sv
// Directed and back-to-back checks of seq_param_multiplier at WIDTH=8 and WIDTH=16.
module tb_seq_param_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst8, iv8, sm8, or8, ir8, ov8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        rst16, iv16, sm16, or16, ir16, ov16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    logic [63:0] sb8[$];
    logic [63:0] sb16[$];

    seq_param_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8),
        .out_ready(or8), .product(p8), .busy(busy8)
    );

    seq_param_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .signed_mode(sm16), .out_valid(ov16),
        .out_ready(or16), .product(p16), .busy(busy16)
    );

    function automatic logic [63:0] ref_mul(int w, logic [63:0] x,
                                            logic [63:0] y, logic sm);
        longint sx, sy;
        int sh;
        sh = 64 - w;
        if (sm) begin
            sx = longint'(x << sh) >>> sh;
            sy = longint'(y << sh) >>> sh;
        end else begin
            sx = longint'(x);
            sy = longint'(y);
        end
        return 64'(sx * sy) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic txn8(input logic [7:0] ta, input logic [7:0] tb,
                        input logic tsm, input logic [15:0] exp,
                        input int stall);
        int lat;
        bit seen;
        logic [63:0] e;
        @(negedge clk);
        check("ready_before_accept", 64'(ir8), 64'd1);
        iv8 = 1'b1; a8 = ta; b8 = tb; sm8 = tsm;
        or8 = (stall == 0);
        @(posedge clk);
        sb8.push_back(64'(exp));
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            if (ov8) begin
                seen = 1;
                iv8 = 1'b0;
            end else begin
                // scramble inputs mid-flight, including a spurious in_valid
                iv8 = 1'($urandom); a8 = 8'($urandom);
                b8 = 8'($urandom); sm8 = 1'($urandom);
                @(posedge clk);
                lat++;
            end
        end
        iv8 = 1'b0;
        if (!seen) check("latency_timeout", 64'd0, 64'd1);
        else check("latency", 64'(lat), 64'd8);
        e = sb8.pop_front();
        check("product8", 64'(p8), e);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(ov8), 64'd1);
            check("stall_product", 64'(p8), e);
            check("stall_ready", 64'(ir8), 64'd0);
        end
        or8 = 1'b1;
        @(negedge clk);
        check("post_valid", 64'(ov8), 64'd0);
        check("post_ready", 64'(ir8), 64'd1);
        check("post_product_hold", 64'(p8), e);
    endtask

    task automatic b2b8(input int n);
        int last_acc, guard;
        logic [7:0] ra, rb;
        logic rs;
        or8 = 1'b1; last_acc = -1;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin @(negedge clk); guard++; end while (!ir8 && guard < 50);
            if (!ir8) begin check("b2b8_accept_timeout", 64'd0, 64'd1); break; end
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            iv8 = 1'b1; a8 = ra; b8 = rb; sm8 = rs;
            sb8.push_back(ref_mul(8, 64'(ra), 64'(rb), rs));
            if (last_acc >= 0) check("b2b8_interval", 64'(cyc - last_acc), 64'd10);
            last_acc = cyc;
            guard = 0;
            do begin @(negedge clk); guard++; end while (!ov8 && guard < 50);
            if (!ov8) begin check("b2b8_out_timeout", 64'd0, 64'd1); break; end
            check("b2b8_product", 64'(p8), sb8.pop_front());
        end
        iv8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic b2b16(input int n);
        int last_acc, guard;
        logic [15:0] ra, rb;
        logic rs;
        or16 = 1'b1; last_acc = -1;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin @(negedge clk); guard++; end while (!ir16 && guard < 80);
            if (!ir16) begin check("b2b16_accept_timeout", 64'd0, 64'd1); break; end
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            if (i == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b1; end
            if (i == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; rs = 1'b0; end
            iv16 = 1'b1; a16 = ra; b16 = rb; sm16 = rs;
            sb16.push_back(ref_mul(16, 64'(ra), 64'(rb), rs));
            if (last_acc >= 0) check("b2b16_interval", 64'(cyc - last_acc), 64'd18);
            last_acc = cyc;
            guard = 0;
            do begin @(negedge clk); guard++; end while (!ov16 && guard < 80);
            if (!ov16) begin check("b2b16_out_timeout", 64'd0, 64'd1); break; end
            check("b2b16_product", 64'(p16), sb16.pop_front());
        end
        iv16 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; or8 = 1'b1;
        rst16 = 1'b1; iv16 = 1'b0; a16 = '0; b16 = '0; sm16 = 1'b0; or16 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(ir8), 64'd0);
        check("rst_out_valid", 64'(ov8), 64'd0);
        check("rst_product", 64'(p8), 64'd0);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst16_product", 64'(p16), 64'd0);
        rst8 = 1'b0; rst16 = 1'b0;
        #1;
        check("rel_in_ready8", 64'(ir8), 64'd1);
        check("rel_in_ready16", 64'(ir16), 64'd1);

        txn8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
        txn8(8'h80, 8'h80, 1'b1, 16'h4000, 0);
        txn8(8'h80, 8'h7F, 1'b1, 16'hC080, 0);
        txn8(8'hFF, 8'h01, 1'b1, 16'hFFFF, 0);
        txn8(8'hFF, 8'hFF, 1'b1, 16'h0001, 20);
        txn8(8'h00, 8'hA5, 1'b0, 16'h0000, 0);
        txn8(8'h5A, 8'h00, 1'b1, 16'h0000, 0);
        txn8(8'h7F, 8'h80, 1'b0, 16'h3F80, 0);

        // abandon a transaction with an async reset pulse at count=3
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'hAB; b8 = 8'hCD; sm8 = 1'b0;
        @(posedge clk);
        sb8.push_back(ref_mul(8, 64'h00AB, 64'h00CD, 1'b0));
        #1 iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst8 = 1'b1;
        #1;
        check("midrun_rst_valid", 64'(ov8), 64'd0);
        check("midrun_rst_busy", 64'(busy8), 64'd0);
        check("midrun_rst_ready", 64'(ir8), 64'd0);
        check("midrun_rst_product", 64'(p8), 64'd0);
        void'(sb8.pop_back());
        @(negedge clk);
        rst8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_stale_valid", 64'(ov8), 64'd0);
        end
        txn8(8'd3, 8'd5, 1'b0, 16'h000F, 0);

        b2b8(1000);
        b2b16(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_param_multiplier.md
Name: seq_param_multiplier

Overview:
Multi-cycle shift-add multiplier that succeeds the combinational param_multiplier. It adds valid/ready handshakes on input and output, selects signed or unsigned operation per transaction, and computes one partial product per clock. It sits on datapaths that cannot afford a full WIDTH x WIDTH combinational array and can tolerate WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand transfer request.
in_ready  output  1  block can accept operands.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  1 = two's-complement operands and product, 0 = unsigned; sampled with a and b.
out_valid  output  1  product is valid.
out_ready  input  1  consumer accepts the product.
product  output  2*WIDTH  result, exact with no truncation.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset:
  - rst high forces the state to IDLE at once, regardless of clk.
  - out_valid=0, product=0, busy=0, internal counter and accumulator = 0.
  - in_ready=0 while rst is high. in_ready=1 in the first cycle after rst deasserts.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) && !rst. in_ready does not depend combinationally on in_valid.
- IDLE:
  - An input transfer happens on a clk edge with in_valid && in_ready.
  - On transfer, capture signed_mode, sign(a), sign(b) and the magnitudes |a|, |b| as unsigned WIDTH-bit values. In signed mode the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which is exact in WIDTH unsigned bits.
  - On transfer, clear the accumulator, set count=0 and go to RUN.
  - If in_valid is low, stay in IDLE.
- RUN:
  - Each edge handles bit[count] of |b|: when it is 1, add |a| << count to the 2*WIDTH-bit accumulator. Then count increments.
  - After the edge that handles bit WIDTH-1 (the WIDTH-th RUN edge), go to DONE.
  - On that same edge, load product with the accumulator, two's-complement negated when signed_mode=1 and sign(a) != sign(b).
- Latency:
  - Input transfer at edge E0 gives out_valid=1 right after edge E0+WIDTH.
  - Minimum interval between accepted transactions is WIDTH+2 cycles (E0, WIDTH RUN edges, one DONE edge with out_ready=1).
- DONE:
  - out_valid=1. product is held stable until the output transfer.
  - An output transfer happens on an edge with out_valid && out_ready. On transfer go to IDLE and clear out_valid.
  - product keeps its last value after the transfer. It changes only on the next RUN-to-DONE edge or on reset.
  - If out_ready is low, stay in DONE indefinitely.
- In RUN and DONE:
  - New in_valid is ignored.
  - Changes on a, b and signed_mode have no effect on the transaction in flight.
- No input transfer can occur on the same edge as an output transfer: in_ready is low in DONE, so there is no bypass.
- Zero operand: RUN still takes all WIDTH cycles (no early termination), so latency is constant.
- Reset during RUN or DONE: the transaction is abandoned and no out_valid pulse appears for it. The next accepted transaction runs cleanly.
- Arithmetic:
  - Unsigned mode: product = a*b, which never exceeds (2^WIDTH-1)^2 < 2^(2*WIDTH).
  - Signed mode: product = the signed a*b, which lies in [-2^(2W-2)+2^(W-1), 2^(2W-2)]; representable, no overflow.
- Protocol assumption for verification: a, b and signed_mode only need to be stable at the transfer edge.

Test Plan:
- Reset release, then unsigned a=0xFF, b=0xFF (WIDTH=8) -> out_valid exactly 8 cycles after the accept edge, product=0xFE01.
- signed_mode=1:
  - a=0x80 (-128), b=0x80 -> product=0x4000.
  - a=0x80, b=0x7F -> product=0xC080 (-16256).
  - a=0xFF (-1), b=0x01 -> product=0xFFFF.
  - Same a=0xFF, b=0xFF as the unsigned case -> product=0x0001.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, product stays stable, in_ready stays 0. Then raise out_ready -> one transfer, and in_ready=1 the following cycle.
- Operand change: toggle a, b and signed_mode during RUN -> result matches the operands captured at accept.
  - a=0 or b=0 -> product=0 after the full 8-cycle latency.
- Asynchronous reset pulse in mid-RUN (count=3) -> out_valid=0, busy=0 and in_ready=0 immediately. No stale out_valid after release. The next transaction 3*5 returns 0x000F.
- Back-to-back: out_ready tied 1, in_valid tied 1 with random operands for 1000 transactions (WIDTH=8 and WIDTH=16) -> every product matches the reference a*b for its mode, and the accept interval is exactly WIDTH+2 cycles.
